// File: rtl/demux_pkg.sv
// Shared definitions for the 4-slot registered demultiplexer.
package demux_pkg;

    localparam int LARGURA  = 32;
    localparam int N_SAIDAS = 4;

    typedef logic [1:0] sel_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/slot_saida32bits.sv
// One output slot: data register plus valid flag. A load wins over a consume.
module slot_saida32bits #(
    parameter int LARGURA = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               carga,
    input  logic               consumo,
    input  logic [LARGURA-1:0] dados,
    output logic [LARGURA-1:0] saida,
    output logic               valida
);

    always_ff @(posedge clk) begin
        if (reset) begin
            saida  <= '0;
            valida <= 1'b0;
        end else if (carga) begin
            saida  <= dados;
            valida <= 1'b1;
        end else if (consumo) begin
            // data is kept; only the valid flag drops
            valida <= 1'b0;
        end
    end

endmodule

// File: rtl/demux4saidas32bits.sv
// Write demultiplexer into four handshaked output slots, with occupancy count
// and a sticky flag for consumes on empty slots.
module demux4saidas32bits
    import demux_pkg::*;
#(
    parameter int LARGURA  = demux_pkg::LARGURA,
    parameter int N_SAIDAS = demux_pkg::N_SAIDAS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         controlador,
    input  logic [LARGURA-1:0] entrada,
    input  logic               escrita_valida,
    output logic               pronto,
    output logic [LARGURA-1:0] saida0,
    output logic [LARGURA-1:0] saida1,
    output logic [LARGURA-1:0] saida2,
    output logic [LARGURA-1:0] saida3,
    output logic [3:0]         saida_valida,
    input  logic [3:0]         consumo,
    output logic [2:0]         ocupados,
    output logic               erro_consumo
);

    sel_t               sel;
    logic               aceita;
    logic [3:0]         carga;
    logic [3:0]         valida_prox;
    logic [LARGURA-1:0] saida [4];

    assign sel    = controlador;
    assign pronto = !saida_valida[sel] || consumo[sel];
    assign aceita = escrita_valida && pronto;

    always_comb begin
        carga = 4'b0000;
        if (aceita) begin
            carga[sel] = 1'b1;
        end
    end

    // mirrors the slot update rule so the count lands on the same edge
    assign valida_prox = carga | (saida_valida & ~consumo);

    for (genvar i = 0; i < 4; i++) begin : g_slot
        slot_saida32bits #(.LARGURA(LARGURA)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .carga   (carga[i]),
            .consumo (consumo[i]),
            .dados   (entrada),
            .saida   (saida[i]),
            .valida  (saida_valida[i])
        );
    end

    assign saida0 = saida[0];
    assign saida1 = saida[1];
    assign saida2 = saida[2];
    assign saida3 = saida[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            ocupados     <= 3'd0;
            erro_consumo <= 1'b0;
        end else begin
            ocupados <= popcount4(valida_prox);
            if (|(consumo & ~saida_valida)) begin
                erro_consumo <= 1'b1;
            end
        end
    end

endmodule
